// File: rtl/rv_fetch_pkg.sv
// Shared types and defaults for the RV32I instruction fetch stage.
package rv_fetch_pkg;

  localparam int FETCH_ADDR_W   = 12;
  localparam int FETCH_IR_W     = 32;
  localparam int FETCH_DEPTH    = 4;
  localparam int FETCH_RESET_PC = 0;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_IR_W-1:0]   instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it, even while popping.
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_entry,
  input  logic                   i_pop,
  output fetch_entry_t           o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_cnt;
  logic           w_wr;
  logic           w_rd;

  assign w_wr = i_push && !i_flush;
  assign w_rd = i_pop && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_entry;
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  assign o_valid = (r_cnt != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_cnt;

endmodule

// File: rtl/rv_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues credit-limited word reads and
// queues returned instructions for decode; supports redirect and halt.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int IR_W     = FETCH_IR_W,
  parameter int DEPTH    = FETCH_DEPTH,
  parameter int RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [IR_W-1:0]   mem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [IR_W-1:0]   instr_data_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic              halted_o
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_V = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CW-1:0]     r_outst;
  logic [CW-1:0]     r_discard;
  logic [CW-1:0]     w_outst_nxt;
  logic [CW-1:0]     w_fifo_cnt;
  logic [CW:0]       w_inflight;
  logic              w_gnt;
  logic              w_push;
  logic              w_pop;
  logic              w_head_vld;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // Credit uses registered counts only, so a pop never frees a slot early.
  assign w_inflight = {1'b0, w_fifo_cnt} + {1'b0, r_outst};
  assign mem_req_o  = rst_n && (r_state == FETCH) && (w_inflight < DEPTH_V);
  assign mem_addr_o = r_fetch_pc;
  assign halted_o   = (r_state == HALTED);

  assign w_gnt        = mem_req_o && mem_gnt_i;
  assign w_outst_nxt  = r_outst + {{(CW-1){1'b0}}, w_gnt} - {{(CW-1){1'b0}}, mem_rvalid_i};
  assign w_push       = mem_rvalid_i && (r_discard == '0) && !redirect_i;
  assign w_push_entry = '{pc: r_resp_pc, instr: mem_rdata_i};
  assign w_pop        = w_head_vld && instr_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH:  if (!redirect_i && halt_i) w_state_nxt = HALTED;
      HALTED: if (redirect_i)            w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_fetch_pc <= PC_RST;
      r_resp_pc  <= PC_RST;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_outst <= w_outst_nxt;
      if (redirect_i) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= redirect_pc_i;
        r_resp_pc  <= redirect_pc_i;
        r_discard  <= w_outst_nxt;
      end else begin
        if (w_gnt) r_fetch_pc <= r_fetch_pc + 1'b1;
        if (mem_rvalid_i) begin
          if (r_discard != '0) r_discard <= r_discard - 1'b1;
          else                 r_resp_pc <= r_resp_pc + 1'b1;
        end
      end
    end
  end

  rv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_head_vld),
    .o_count (w_fifo_cnt)
  );

  assign instr_valid_o = w_head_vld;
  assign instr_data_o  = w_head.instr;
  assign instr_pc_o    = w_head.pc;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit with a fixed-latency in-order memory model.
module tb_rv_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_req_o;
  logic [11:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_data_o;
  logic [11:0] instr_pc_o;
  logic        redirect_i;
  logic [11:0] redirect_pc_i;
  logic        halt_i;
  logic        halted_o;

  rv_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_data_o  (instr_data_o),
    .instr_pc_o    (instr_pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .halted_o      (halted_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [4096];
  int          lat = 1;
  bit          gnt_en = 1'b1;
  int          gnt_cnt = 0;
  int          cyc = 0;
  int          last_due = 0;
  logic [11:0] q_addr [$];
  int          q_due [$];
  int          n_vec = 0;
  int          n_err = 0;

  // Memory responder: outputs change 1 unit after posedge, requests are
  // sampled mid-cycle after the main process has driven its inputs.
  initial begin
    int due;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (!rst_n) begin
        q_addr.delete();
        q_due.delete();
        last_due = cyc;
      end else if (q_due.size() > 0 && q_due[0] == cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem[q_addr[0]];
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      mem_gnt_i = gnt_en;
      @(negedge clk); #2;
      if (mem_req_o && mem_gnt_i) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        q_addr.push_back(mem_addr_o);
        q_due.push_back(due);
        gnt_cnt++;
      end
    end
  end

  // Leaves the caller at a negedge with rst_n still low; setting rst_n=1
  // there makes the current cycle "cycle 0".
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    halt_i = 1'b0; gnt_en = 1'b1; lat = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (mem_req_o !== 1'b0)      begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    n_vec++; if (mem_addr_o !== 12'h000)  begin n_err++; $display("FAIL reset_addr: got %h want 000", mem_addr_o); end
    n_vec++; if (instr_valid_o !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    n_vec++; if (instr_data_o !== 32'h0)  begin n_err++; $display("FAIL reset_data: got %h want 0", instr_data_o); end
    n_vec++; if (instr_pc_o !== 12'h000)  begin n_err++; $display("FAIL reset_pc: got %h want 000", instr_pc_o); end
    n_vec++; if (halted_o !== 1'b0)       begin n_err++; $display("FAIL reset_halted: got %b want 0", halted_o); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_d [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00000073};
    rst_n = 1'b1; instr_ready_i = 1'b1;
    #1;
    n_vec++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL stream_first_req: got %b want 1", mem_req_o); end
    @(negedge clk);
    n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_c1_valid: got %b want 0", instr_valid_o); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++; if (instr_valid_o !== 1'b1)   begin n_err++; $display("FAIL stream_valid%0d: got %b want 1", k, instr_valid_o); end
      n_vec++; if (instr_pc_o !== 12'(k))    begin n_err++; $display("FAIL stream_pc%0d: got %h want %h", k, instr_pc_o, 12'(k)); end
      n_vec++; if (instr_data_o !== exp_d[k]) begin n_err++; $display("FAIL stream_data%0d: got %h want %h", k, instr_data_o, exp_d[k]); end
    end
  endtask

  task automatic test_backpressure();
    int g0;
    do_reset();
    rst_n = 1'b1;
    g0 = gnt_cnt;
    repeat (10) @(negedge clk);
    n_vec++; if (gnt_cnt - g0 !== 4)      begin n_err++; $display("FAIL bp_grants: got %0d want 4", gnt_cnt - g0); end
    n_vec++; if (mem_req_o !== 1'b0)      begin n_err++; $display("FAIL bp_req: got %b want 0", mem_req_o); end
    n_vec++; if (instr_valid_o !== 1'b1)  begin n_err++; $display("FAIL bp_hold_valid: got %b want 1", instr_valid_o); end
    n_vec++; if (instr_pc_o !== 12'h000)  begin n_err++; $display("FAIL bp_hold_pc: got %h want 000", instr_pc_o); end
    instr_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_vec++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d: got %b want 1", k, instr_valid_o); end
      n_vec++; if (instr_pc_o !== 12'(k))  begin n_err++; $display("FAIL bp_pc%0d: got %h want %h", k, instr_pc_o, 12'(k)); end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    rst_n = 1'b1; lat = 3; instr_ready_i = 1'b1;
    @(negedge clk);
    gnt_en = 1'b0;
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 12'h100; gnt_en = 1'b1;
    @(negedge clk);
    redirect_i = 1'b0;
    n_vec++; if (mem_req_o !== 1'b1)     begin n_err++; $display("FAIL rdi_req: got %b want 1", mem_req_o); end
    n_vec++; if (mem_addr_o !== 12'h100) begin n_err++; $display("FAIL rdi_addr: got %h want 100", mem_addr_o); end
    for (int c = 3; c <= 6; c++) begin
      if (c > 3) @(negedge clk);
      n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rdi_stale_c%0d: valid got %b want 0 (pc %h)", c, instr_valid_o, instr_pc_o); end
    end
    @(negedge clk);
    n_vec++; if (instr_valid_o !== 1'b1)   begin n_err++; $display("FAIL rdi_valid: got %b want 1", instr_valid_o); end
    n_vec++; if (instr_pc_o !== 12'h100)   begin n_err++; $display("FAIL rdi_pc: got %h want 100", instr_pc_o); end
    n_vec++; if (instr_data_o !== mem[256]) begin n_err++; $display("FAIL rdi_data: got %h want %h", instr_data_o, mem[256]); end
    @(negedge clk);
    n_vec++; if (instr_pc_o !== 12'h101)   begin n_err++; $display("FAIL rdi_pc_next: got %h want 101", instr_pc_o); end
  endtask

  task automatic test_redirect_handshake();
    do_reset();
    rst_n = 1'b1; instr_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 12'h001) begin n_err++; $display("FAIL rdh_consumed: got v=%b pc=%h want v=1 pc=001", instr_valid_o, instr_pc_o); end
    redirect_i = 1'b1; redirect_pc_i = 12'h040;
    @(negedge clk);
    redirect_i = 1'b0;
    n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rdh_c4_valid: got %b want 0 (pc %h)", instr_valid_o, instr_pc_o); end
    @(negedge clk);
    n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rdh_c5_valid: got %b want 0 (pc %h)", instr_valid_o, instr_pc_o); end
    @(negedge clk);
    n_vec++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 12'h040) begin n_err++; $display("FAIL rdh_new_pc: got v=%b pc=%h want v=1 pc=040", instr_valid_o, instr_pc_o); end
    n_vec++; if (instr_data_o !== mem[64]) begin n_err++; $display("FAIL rdh_new_data: got %h want %h", instr_data_o, mem[64]); end
    @(negedge clk);
    n_vec++; if (instr_pc_o !== 12'h041) begin n_err++; $display("FAIL rdh_next_pc: got %h want 041", instr_pc_o); end
  endtask

  task automatic test_halt();
    int g0;
    do_reset();
    rst_n = 1'b1; instr_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if (instr_pc_o !== 12'h003) begin n_err++; $display("FAIL halt_at_pc: got %h want 003", instr_pc_o); end
    halt_i = 1'b1;
    @(negedge clk);
    halt_i = 1'b0;
    g0 = gnt_cnt;
    n_vec++; if (halted_o !== 1'b1)  begin n_err++; $display("FAIL halt_flag: got %b want 1", halted_o); end
    n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL halt_req: got %b want 0", mem_req_o); end
    n_vec++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 12'h004) begin n_err++; $display("FAIL halt_drain4: got v=%b pc=%h want v=1 pc=004", instr_valid_o, instr_pc_o); end
    @(negedge clk);
    n_vec++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 12'h005) begin n_err++; $display("FAIL halt_drain5: got v=%b pc=%h want v=1 pc=005", instr_valid_o, instr_pc_o); end
    @(negedge clk);
    n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL halt_empty: got %b want 0", instr_valid_o); end
    @(negedge clk);
    n_vec++; if (gnt_cnt !== g0)     begin n_err++; $display("FAIL halt_no_grant: got %0d want %0d", gnt_cnt, g0); end
    n_vec++; if (halted_o !== 1'b1)  begin n_err++; $display("FAIL halt_stays: got %b want 1", halted_o); end
    redirect_i = 1'b1; redirect_pc_i = 12'h000;
    @(negedge clk);
    redirect_i = 1'b0;
    n_vec++; if (halted_o !== 1'b0)  begin n_err++; $display("FAIL halt_resume_flag: got %b want 0", halted_o); end
    n_vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 12'h000) begin n_err++; $display("FAIL halt_resume_req: got req=%b addr=%h want req=1 addr=000", mem_req_o, mem_addr_o); end
    repeat (2) @(negedge clk);
    n_vec++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 12'h000) begin n_err++; $display("FAIL halt_resume_pc0: got v=%b pc=%h want v=1 pc=000", instr_valid_o, instr_pc_o); end
    @(negedge clk);
    n_vec++; if (instr_pc_o !== 12'h001) begin n_err++; $display("FAIL halt_resume_pc1: got %h want 001", instr_pc_o); end
  endtask

  task automatic test_wrap();
    logic [11:0] wpc [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    do_reset();
    rst_n = 1'b1; instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 12'hFFE;
    @(negedge clk);
    redirect_i = 1'b0;
    n_vec++; if (mem_addr_o !== 12'hFFE) begin n_err++; $display("FAIL wrap_addr: got %h want ffe", mem_addr_o); end
    @(negedge clk);
    n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL wrap_c2_valid: got %b want 0", instr_valid_o); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++; if (instr_valid_o !== 1'b1 || instr_pc_o !== wpc[k]) begin n_err++; $display("FAIL wrap_pc%0d: got v=%b pc=%h want v=1 pc=%h", k, instr_valid_o, instr_pc_o, wpc[k]); end
      n_vec++; if (instr_data_o !== mem[wpc[k]]) begin n_err++; $display("FAIL wrap_data%0d: got %h want %h", k, instr_data_o, mem[wpc[k]]); end
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_req_o !== 1'b0)      begin n_err++; $display("FAIL midrst_req: got %b want 0", mem_req_o); end
    n_vec++; if (mem_addr_o !== 12'h000)  begin n_err++; $display("FAIL midrst_addr: got %h want 000", mem_addr_o); end
    n_vec++; if (instr_valid_o !== 1'b0)  begin n_err++; $display("FAIL midrst_valid: got %b want 0", instr_valid_o); end
    n_vec++; if (instr_data_o !== 32'h0)  begin n_err++; $display("FAIL midrst_data: got %h want 0", instr_data_o); end
    n_vec++; if (instr_pc_o !== 12'h000)  begin n_err++; $display("FAIL midrst_pc: got %h want 000", instr_pc_o); end
    n_vec++; if (halted_o !== 1'b0)       begin n_err++; $display("FAIL midrst_halted: got %b want 0", halted_o); end
  endtask

  initial begin
    rst_n = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'h00000013;
    mem[1] = 32'h00100093;
    mem[2] = 32'h00200113;
    mem[3] = 32'h00000073;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_handshake();
    test_halt();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
